// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: pipelined RV32I-style integer ALU functional unit.
// Accepts one issued RS entry per cycle, computes the result combinationally
// at issue, and carries it through STAGES register stages to the CDB.
// Valid/ready on both sides; mispredict flushes entries younger than the
// mispredicted branch, where age is measured from the ROB head.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   issue_valid / issue_ready       RS handshake (issue_ready combinational)
//   issue_opcode/func3/func7/imm    decoded instruction fields
//   issue_pd, issue_rob             destination preg, ROB tag
//   ps1_data, ps2_data              register operands
//   rob_head                        oldest ROB tag
//   mispredict, mispredict_tag      flush pulse and branch tag
//   out_valid / out_ready           CDB handshake
//   out_pd, out_rob, out_data       result payload
//   out_illegal                     unsupported encoding flag
module fu_alu_pipe #(
  parameter int XLEN      = 32,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 5,
  parameter int ROB_DEPTH = 16,
  parameter int STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [6:0]        issue_opcode,
  input  logic [2:0]        issue_func3,
  input  logic [6:0]        issue_func7,
  input  logic [XLEN-1:0]   issue_imm,
  input  logic [PREG_W-1:0] issue_pd,
  input  logic [ROB_W-1:0]  issue_rob,
  input  logic [XLEN-1:0]   ps1_data,
  input  logic [XLEN-1:0]   ps2_data,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_pd,
  output logic [ROB_W-1:0]  out_rob,
  output logic [XLEN-1:0]   out_data,
  output logic              out_illegal
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  // Immediate shifts: only func7[5] (and func7[0] as shamt bit 5 on wider
  // datapaths) may be set.
  localparam logic [6:0] F7_SHIFT_MASK = (XLEN > 32) ? 7'b1011110 : 7'b1011111;
  localparam logic [ROB_W:0] DEPTH_W = (ROB_W+1)'(ROB_DEPTH);

  // ---------------------------------------------------------------- ALU
  logic [XLEN-1:0] op_b;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            imm_shift_ok;

  always_comb begin
    op_b         = (issue_opcode == OPC_OP_IMM) ? issue_imm : ps2_data;
    shamt        = op_b[SH_W-1:0];
    imm_shift_ok = ((issue_func7 & F7_SHIFT_MASK) == 7'b0);
    alu_res      = '0;
    alu_ill      = 1'b0;
    case (issue_opcode)
      OPC_OP_IMM: begin
        case (issue_func3)
          3'b000: alu_res = ps1_data + op_b;
          3'b001: begin
            if (imm_shift_ok && !issue_func7[5]) alu_res = ps1_data << shamt;
            else alu_ill = 1'b1;
          end
          3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(ps1_data) < $signed(op_b)};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, ps1_data < op_b};
          3'b100: alu_res = ps1_data ^ op_b;
          3'b101: begin
            if (!imm_shift_ok)       alu_ill = 1'b1;
            else if (issue_func7[5]) alu_res = $unsigned($signed(ps1_data) >>> shamt);
            else                     alu_res = ps1_data >> shamt;
          end
          3'b110: alu_res = ps1_data | op_b;
          default: alu_res = ps1_data & op_b;
        endcase
      end
      OPC_OP: begin
        if (issue_func7 == 7'b0000000) begin
          case (issue_func3)
            3'b000: alu_res = ps1_data + op_b;
            3'b001: alu_res = ps1_data << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(ps1_data) < $signed(op_b)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, ps1_data < op_b};
            3'b100: alu_res = ps1_data ^ op_b;
            3'b101: alu_res = ps1_data >> shamt;
            3'b110: alu_res = ps1_data | op_b;
            default: alu_res = ps1_data & op_b;
          endcase
        end else if (issue_func7 == 7'b0100000 && issue_func3 == 3'b000) begin
          alu_res = ps1_data - op_b;
        end else if (issue_func7 == 7'b0100000 && issue_func3 == 3'b101) begin
          alu_res = $unsigned($signed(ps1_data) >>> shamt);
        end else begin
          alu_ill = 1'b1;
        end
      end
      OPC_LUI: alu_res = issue_imm;
      default: alu_ill = 1'b1;
    endcase
    // Illegal encodings always report zero data.
    if (alu_ill) alu_res = '0;
  end

  // ---------------------------------------------------------------- flush
  function automatic logic [ROB_W:0] age_of(input logic [ROB_W-1:0] tag,
                                            input logic [ROB_W-1:0] head);
    logic [ROB_W:0] t;
    logic [ROB_W:0] h;
    t = {1'b0, tag};
    h = {1'b0, head};
    if (t >= h) age_of = t - h;
    else        age_of = t + DEPTH_W - h;
  endfunction

  logic [STAGES:1]  st_valid;
  logic [STAGES:1]  st_ill;
  logic [PREG_W-1:0] st_pd   [1:STAGES];
  logic [ROB_W-1:0]  st_rob  [1:STAGES];
  logic [XLEN-1:0]   st_data [1:STAGES];

  logic [ROB_W:0]  br_age;
  logic            issue_kill;
  logic [STAGES:1] kill;

  always_comb begin
    br_age     = age_of(mispredict_tag, rob_head);
    issue_kill = mispredict && (age_of(issue_rob, rob_head) > br_age);
    for (int k = 1; k <= STAGES; k++)
      kill[k] = mispredict && st_valid[k] && (age_of(st_rob[k], rob_head) > br_age);
  end

  // ---------------------------------------------------------------- advance
  logic [STAGES:1] adv;

  always_comb begin
    logic a;
    a = !st_valid[STAGES] || out_ready;
    adv[STAGES] = a;
    for (int k = STAGES - 1; k >= 1; k--) begin
      a = !st_valid[k] || a;
      adv[k] = a;
    end
  end

  assign issue_ready = adv[1];

  // Stage inputs: stage 1 takes the issue slot, later stages their predecessor.
  // A killed source never becomes valid downstream.
  logic [STAGES:1]   src_valid;
  logic [STAGES:1]   src_ill;
  logic [PREG_W-1:0] src_pd   [1:STAGES];
  logic [ROB_W-1:0]  src_rob  [1:STAGES];
  logic [XLEN-1:0]   src_data [1:STAGES];

  always_comb begin
    src_valid[1] = issue_valid && adv[1] && !issue_kill;
    src_ill[1]   = alu_ill;
    src_pd[1]    = issue_pd;
    src_rob[1]   = issue_rob;
    src_data[1]  = alu_res;
    for (int k = 2; k <= STAGES; k++) begin
      src_valid[k] = st_valid[k-1] && !kill[k-1];
      src_ill[k]   = st_ill[k-1];
      src_pd[k]    = st_pd[k-1];
      src_rob[k]   = st_rob[k-1];
      src_data[k]  = st_data[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        st_valid[k] <= 1'b0;
        st_ill[k]   <= 1'b0;
        st_pd[k]    <= '0;
        st_rob[k]   <= '0;
        st_data[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (adv[k]) begin
          st_valid[k] <= src_valid[k];
          // Payload only moves with a live entry so outputs stay quiet otherwise.
          if (src_valid[k]) begin
            st_ill[k]  <= src_ill[k];
            st_pd[k]   <= src_pd[k];
            st_rob[k]  <= src_rob[k];
            st_data[k] <= src_data[k];
          end
        end else begin
          st_valid[k] <= st_valid[k] && !kill[k];
        end
      end
    end
  end

  assign out_valid   = st_valid[STAGES];
  assign out_illegal = st_ill[STAGES];
  assign out_pd      = st_pd[STAGES];
  assign out_rob     = st_rob[STAGES];
  assign out_data    = st_data[STAGES];

endmodule
